// File: rtl/chronologic.sv
// Pulse-width checker: measures high pulses on sig_in and flags short/long/legal pulses.
// Optional statistics counters are built when CHRONOLOGIC_STATS_EN is defined.
module chronologic #(
  parameter int MIN_HIGH = 2,
  parameter int MAX_HIGH = 6,
  parameter int CNT_W    = 16,
  localparam int RL_W    = $clog2(MAX_HIGH + 2)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            sig_in,
  input  logic            clr,
  output logic            pulse_ok,
  output logic            err_short,
  output logic            err_long,
  output logic            err_sticky,
  output logic            busy,
  output logic [RL_W-1:0] run_len
`ifdef CHRONOLOGIC_STATS_EN
  ,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count
`endif
);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [RL_W-1:0]   run_len_q, run_len_d;
  logic              pulse_ok_q, pulse_ok_d;
  logic              err_short_q, err_short_d;
  logic              err_long_q, err_long_d;
  logic              err_sticky_q, err_sticky_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    pulse_ok_d  = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    if (!en) begin
      // Disabling drops any pulse in flight; re-enabling must first see sig_in low.
      state_d = ST_ARM;
    end else begin
      unique case (state_q)
        ST_ARM: begin
          if (!sig_in) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (sig_in) begin
            state_d   = ST_HIGH;
            run_len_d = RL_W'(1);
          end
        end
        ST_HIGH: begin
          if (sig_in) begin
            if (run_len_q == RL_W'(MAX_HIGH)) begin
              state_d    = ST_OVER;
              run_len_d  = RL_W'(MAX_HIGH + 1);
              err_long_d = 1'b1;
            end else begin
              run_len_d = run_len_q + RL_W'(1);
            end
          end else begin
            state_d = ST_IDLE;
            if (run_len_q < RL_W'(MIN_HIGH)) err_short_d = 1'b1;
            else                             pulse_ok_d  = 1'b1;
          end
        end
        ST_OVER: begin
          if (!sig_in) state_d = ST_IDLE;
        end
        default: state_d = ST_ARM;
      endcase
    end
    busy_d = (state_d == ST_HIGH) || (state_d == ST_OVER);
    // A new error outranks a simultaneous clear.
    if (err_short_d || err_long_d) err_sticky_d = 1'b1;
    else if (clr)                  err_sticky_d = 1'b0;
    else                           err_sticky_d = err_sticky_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARM;
      run_len_q    <= '0;
      pulse_ok_q   <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_len_q    <= run_len_d;
      pulse_ok_q   <= pulse_ok_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      err_sticky_q <= err_sticky_d;
      busy_q       <= busy_d;
    end
  end

  assign pulse_ok   = pulse_ok_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;
  assign err_sticky = err_sticky_q;
  assign busy       = busy_q;
  assign run_len    = run_len_q;

`ifdef CHRONOLOGIC_STATS_EN
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Clear-then-count lets a same-cycle event survive the clear as a count of one.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic clear, input logic ev);
    logic [CNT_W-1:0] base;
    base = clear ? '0 : cur;
    if (ev && (base != '1)) return base + CNT_W'(1);
    return base;
  endfunction

  always_comb begin
    ok_cnt_d  = cnt_next(ok_cnt_q, clr, pulse_ok_d);
    err_cnt_d = cnt_next(err_cnt_q, clr, err_short_d || err_long_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ok_count  = ok_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_chronologic.sv
// Directed bench for chronologic with default parameters (MIN_HIGH=2, MAX_HIGH=6).
// Counter checks are compiled in when CHRONOLOGIC_STATS_EN is defined.
module tb_chronologic;
  logic       clk = 1'b0;
  logic       rst_n, en, sig_in, clr;
  logic       pulse_ok, err_short, err_long, err_sticky, busy;
  logic [2:0] run_len;
`ifdef CHRONOLOGIC_STATS_EN
  logic [15:0] ok_count, err_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  chronologic dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .clr(clr),
    .pulse_ok(pulse_ok), .err_short(err_short), .err_long(err_long),
    .err_sticky(err_sticky), .busy(busy), .run_len(run_len)
`ifdef CHRONOLOGIC_STATS_EN
    , .ok_count(ok_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes packed as {pulse_ok, err_short, err_long}.
  task automatic chk_st(input string tag, input logic [2:0] exp);
    chk(tag, 32'({pulse_ok, err_short, err_long}), 32'(exp));
  endtask

  // Drive a high pulse of n samples, then one low sample; returns just after the deciding edge.
  task automatic pulse(input int n);
    sig_in = 1'b1;
    repeat (n) tick();
    sig_in = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; sig_in = 1'b0; clr = 1'b0;
    #12;
    chk_st("rst_strobes", 3'b000);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_run_len", 32'(run_len), 0);
    chk("rst_sticky", 32'(err_sticky), 0);
    #1 rst_n = 1'b1;
    tick();
    tick();

    // 1-cycle pulse: too short
    pulse(1);
    chk_st("p1_strobe", 3'b010);
    chk("p1_run_len", 32'(run_len), 1);
    chk("p1_sticky", 32'(err_sticky), 1);
    tick();
    chk_st("p1_after", 3'b000);
    chk("p1_hold_len", 32'(run_len), 1);

    // 2-cycle pulse: legal minimum
    sig_in = 1'b1;
    tick();
    chk("p2_busy", 32'(busy), 1);
    chk("p2_len1", 32'(run_len), 1);
    tick();
    sig_in = 1'b0;
    tick();
    chk_st("p2_strobe", 3'b100);
    chk("p2_run_len", 32'(run_len), 2);
    chk("p2_busy_end", 32'(busy), 0);
    tick();
    chk_st("p2_after", 3'b000);

    // 6-cycle pulse: legal maximum
    pulse(6);
    chk_st("p6_strobe", 3'b100);
    chk("p6_run_len", 32'(run_len), 6);
    tick();

    // 7-cycle pulse: too long, flagged on the 7th high sample
    sig_in = 1'b1;
    repeat (6) tick();
    chk_st("p7_pre", 3'b000);
    chk("p7_len6", 32'(run_len), 6);
    tick();
    chk_st("p7_long", 3'b001);
    chk("p7_len7", 32'(run_len), 7);
    chk("p7_busy", 32'(busy), 1);
    sig_in = 1'b0;
    tick();
    chk_st("p7_fall", 3'b000);
    chk("p7_len_hold", 32'(run_len), 7);
    chk("p7_busy_end", 32'(busy), 0);
    chk("p7_sticky", 32'(err_sticky), 1);
`ifdef CHRONOLOGIC_STATS_EN
    chk("ok_count_seq", 32'(ok_count), 2);
    chk("err_count_seq", 32'(err_count), 2);
`endif

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_sticky", 32'(err_sticky), 0);
`ifdef CHRONOLOGIC_STATS_EN
    chk("clr_ok_count", 32'(ok_count), 0);
    chk("clr_err_count", 32'(err_count), 0);
`endif

    // Error and clear on the same edge: error wins
    sig_in = 1'b1;
    tick();
    sig_in = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_st("clr_err_strobe", 3'b010);
    chk("clr_err_sticky", 32'(err_sticky), 1);
`ifdef CHRONOLOGIC_STATS_EN
    chk("clr_err_count1", 32'(err_count), 1);
`endif
    tick();

    // en low mid-pulse discards it; the still-high signal is not measured afterwards
    sig_in = 1'b1;
    tick();
    en = 1'b0;
    tick();
    chk("en_busy", 32'(busy), 0);
    chk_st("en_strobes", 3'b000);
    en = 1'b1;
    repeat (2) tick();
    chk("en_arm_busy", 32'(busy), 0);
    sig_in = 1'b0;
    tick();
    chk_st("en_fall", 3'b000);
    pulse(2);
    chk_st("en_p2", 3'b100);
    tick();

    // Asynchronous reset mid-pulse
    sig_in = 1'b1;
    repeat (2) tick();
    chk("mid_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_run_len", 32'(run_len), 0);
    chk("arst_sticky", 32'(err_sticky), 0);
    #3 rst_n = 1'b1;

    // Signal high across reset release: 3 samples high, then low, no strobes
    repeat (3) begin
      tick();
      chk_st("rel_high", 3'b000);
      chk("rel_busy", 32'(busy), 0);
    end
    sig_in = 1'b0;
    tick();
    chk_st("rel_fall", 3'b000);
    pulse(2);
    chk_st("rel_p2", 3'b100);
    chk("rel_p2_len", 32'(run_len), 2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
